// File: rtl/alu_exec_unit.sv
// Sequential ALU: valid/ready request in, valid/ready response out; shifts iterate one bit per cycle.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter (SHIFT state never entered).
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic [3:0]       CTRL,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [0:WIDTH-1] OUT,
    output logic             ZERO_SIGNAL,
    output logic             BAD_OP
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SEQ  = 4'b1000;
    localparam logic [3:0] OP_SNE  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SGT  = 4'b1011;
    localparam logic [3:0] OP_SLE  = 4'b1100;
    localparam logic [3:0] OP_SGE  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1110;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    logic               r_live;
    logic [0:WIDTH-1]   r_out;
    logic               r_rsp_valid;
    logic               r_bad;

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;
    logic               w_eq;
    logic               w_lt_s;
    logic               w_lt_u;
    logic [0:WIDTH-1]   w_result;

    assign w_shamt = B[WIDTH-SHAMT_W:WIDTH-1];
    assign w_eq    = (A == B);
    assign w_lt_s  = ($signed(A) < $signed(B));
    assign w_lt_u  = (A < B);

    // r_live keeps REQ_READY low while reset is held and for the first edge after it.
    assign REQ_READY = r_live && ((r_state == S_IDLE) || ((r_state == S_DONE) && RSP_READY));
    assign w_accept  = REQ_VALID && REQ_READY;

    // Set-op results land in bit WIDTH-1, the LSB of the big-endian vector.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_result = '0;
        case (CTRL)
            OP_ADD:  w_result = A + B;
            OP_SUB:  w_result = A - B;
            OP_AND:  w_result = A & B;
            OP_OR:   w_result = A | B;
            OP_XOR:  w_result = A ^ B;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  w_result = A << w_shamt;
            OP_SRA:  w_result = $signed(A) >>> w_shamt;
            OP_SRL:  w_result = A >> w_shamt;
`else
            OP_SLL, OP_SRA, OP_SRL: w_result = A;
`endif
            OP_SEQ:  w_result[WIDTH-1] = w_eq;
            OP_SNE:  w_result[WIDTH-1] = !w_eq;
            OP_SLT:  w_result[WIDTH-1] = w_lt_s;
            OP_SGT:  w_result[WIDTH-1] = !w_lt_s && !w_eq;
            OP_SLE:  w_result[WIDTH-1] = w_lt_s || w_eq;
            OP_SGE:  w_result[WIDTH-1] = !w_lt_s;
            OP_SLTU: w_result[WIDTH-1] = w_lt_u;
            OP_BAD:  w_result = '0;
            default: w_result = '0;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic               w_is_shift;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_ctrl;

    assign w_is_shift = (CTRL == OP_SLL) || (CTRL == OP_SRA) || (CTRL == OP_SRL);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_out       <= '0;
            r_rsp_valid <= 1'b0;
            r_bad       <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            r_cnt       <= '0;
            r_ctrl      <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_live <= 1'b1;
            if (w_accept) begin
                r_bad <= (CTRL == OP_BAD);
`ifndef ALU_FAST_SHIFT_EN
                r_ctrl <= CTRL;
                if (w_is_shift && (w_shamt != '0)) begin
                    r_out       <= A;
                    r_cnt       <= w_shamt;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_SHIFT;
                end else
`endif
                begin
                    r_out       <= w_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
            end else begin
                case (r_state)
`ifndef ALU_FAST_SHIFT_EN
                    S_SHIFT: begin
                        case (r_ctrl)
                            OP_SLL:  r_out <= {r_out[1:WIDTH-1], 1'b0};
                            OP_SRA:  r_out <= {r_out[0], r_out[0:WIDTH-2]};
                            default: r_out <= {1'b0, r_out[0:WIDTH-2]};
                        endcase
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == SHAMT_W'(1)) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
`endif
                    S_DONE: begin
                        if (RSP_READY) begin
                            r_rsp_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign OUT         = r_out;
    assign RSP_VALID   = r_rsp_valid;
    assign BAD_OP      = r_bad;
    assign ZERO_SIGNAL = r_rsp_valid && (r_out == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: vector table, backpressure/back-to-back and mid-shift reset.
module tb_alu_exec_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [0:31] A;
    logic [0:31] B;
    logic [3:0]  CTRL;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [0:31] OUT;
    logic        ZERO_SIGNAL;
    logic        BAD_OP;

    int n_pass  = 0;
    int n_total = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .A           (A),
        .B           (B),
        .CTRL        (CTRL),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .OUT         (OUT),
        .ZERO_SIGNAL (ZERO_SIGNAL),
        .BAD_OP      (BAD_OP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_bad;
        int          exp_lat;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Issue one request with RSP_READY low, measure cycles from accept edge to RSP_VALID
    // (sampled on negedges), capture the response, then complete the handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                          output logic [31:0] out, output logic zero, output logic bad,
                          output int lat);
        int guard;
        lat = 0;
        out = '0; zero = 1'b0; bad = 1'b0;
        RSP_READY = 1'b0;
        @(negedge CLK);
        REQ_VALID = 1'b1; A = a; B = b; CTRL = ctrl;
        guard = 0;
        while (!REQ_READY && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        A = 32'hDEADBEEF; B = 32'h0BADF00D; CTRL = 4'b0000;
        guard = 0;
        do begin
            @(negedge CLK);
            lat++;
            guard++;
        end while (!RSP_VALID && guard < 100);
        if (!RSP_VALID) begin
            n_total++;
            $display("FAIL rsp_timeout: RSP_VALID still 0 after %0d cycles", guard);
        end
        out = OUT; zero = ZERO_SIGNAL; bad = BAD_OP;
        RSP_READY = 1'b1;
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;
    endtask

    function automatic int shift_lat(input logic [3:0] ctrl, input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((ctrl == 4'b0100 || ctrl == 4'b0110 || ctrl == 4'b0111) && n != 0) return n + 1;
        return 1;
`endif
    endfunction

    initial begin
        logic [31:0] got_out;
        logic        got_zero;
        logic        got_bad;
        int          got_lat;
        int          stale;

        vecs[0]  = '{"add",       32'h0000F054, 32'h0000005F, 4'b0000, 32'h0000F0B3, 1'b0, 1'b0, 0};
        vecs[1]  = '{"sub_zero",  32'h00000007, 32'h00000007, 4'b0001, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[2]  = '{"add_wrap",  32'hFFFFFFFF, 32'h00000001, 4'b0000, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[3]  = '{"and",       32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, 32'hF000F000, 1'b0, 1'b0, 0};
        vecs[4]  = '{"or",        32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 32'hFFF0FFF0, 1'b0, 1'b0, 0};
        vecs[5]  = '{"xor",       32'hF0F0F0F0, 32'hFF00FF00, 4'b0101, 32'h0FF00FF0, 1'b0, 1'b0, 0};
        vecs[6]  = '{"sll13",     32'h0000FFFF, 32'h0000000D, 4'b0100, 32'h1FFFE000, 1'b0, 1'b0, 0};
        vecs[7]  = '{"sra13",     32'hFFFF0000, 32'h0000000D, 4'b0110, 32'hFFFFFFF8, 1'b0, 1'b0, 0};
        vecs[8]  = '{"srl13",     32'hFFFF0000, 32'h0000000D, 4'b0111, 32'h0007FFF8, 1'b0, 1'b0, 0};
        vecs[9]  = '{"sll31",     32'h00000001, 32'h0000001F, 4'b0100, 32'h80000000, 1'b0, 1'b0, 0};
        vecs[10] = '{"sra31",     32'h80000000, 32'h0000001F, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 0};
        vecs[11] = '{"srl0_hi",   32'h12345678, 32'hFFFFFFE0, 4'b0111, 32'h12345678, 1'b0, 1'b0, 0};
        vecs[12] = '{"srl1_hi",   32'h80000000, 32'hFFFFFFE1, 4'b0111, 32'h40000000, 1'b0, 1'b0, 0};
        vecs[13] = '{"seq",       32'h0000FFFF, 32'h0000FFFF, 4'b1000, 32'h00000001, 1'b0, 1'b0, 0};
        vecs[14] = '{"sne_eq",    32'h00000005, 32'h00000005, 4'b1001, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[15] = '{"slt",       32'hFFFFFFFF, 32'h00000001, 4'b1010, 32'h00000001, 1'b0, 1'b0, 0};
        vecs[16] = '{"sgt",       32'h00000001, 32'hFFFFFFFF, 4'b1011, 32'h00000001, 1'b0, 1'b0, 0};
        vecs[17] = '{"sle_eq",    32'h80000000, 32'h80000000, 4'b1100, 32'h00000001, 1'b0, 1'b0, 0};
        vecs[18] = '{"sge",       32'h80000000, 32'h7FFFFFFF, 4'b1101, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[19] = '{"sltu",      32'hFFFFFFFF, 32'h00000001, 4'b1110, 32'h00000000, 1'b1, 1'b0, 0};
        vecs[20] = '{"bad_op",    32'hFFFFFFFF, 32'h00000001, 4'b1111, 32'h00000000, 1'b1, 1'b1, 0};
        foreach (vecs[i]) vecs[i].exp_lat = shift_lat(vecs[i].ctrl, vecs[i].b);

        RST_N = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
        A = '0; B = '0; CTRL = '0;
        #1;
        check("rst_out",       OUT,         32'h0);
        check("rst_rsp_valid", RSP_VALID,   32'h0);
        check("rst_zero",      ZERO_SIGNAL, 32'h0);
        check("rst_bad",       BAD_OP,      32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_req_ready", REQ_READY, 32'h1);

        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ctrl, got_out, got_zero, got_bad, got_lat);
            check({vecs[i].name, "_out"},  got_out,         vecs[i].exp_out);
            check({vecs[i].name, "_zero"}, 32'(got_zero),   32'(vecs[i].exp_zero));
            check({vecs[i].name, "_bad"},  32'(got_bad),    32'(vecs[i].exp_bad));
            check({vecs[i].name, "_lat"},  32'(got_lat),    32'(vecs[i].exp_lat));
        end

        // Backpressure: response held 5 cycles with a second request waiting, then back-to-back.
        @(negedge CLK);
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1; A = 32'h00000001; B = 32'h00000002; CTRL = 4'b0000;
        @(posedge CLK);
        #1;
        A = 32'h0000000A; B = 32'h00000003; CTRL = 4'b0001;
        @(negedge CLK);
        check("bp_first_valid", RSP_VALID, 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_stable", OUT,       32'h00000003);
            check("bp_req_ready",  REQ_READY, 32'h0);
            @(negedge CLK);
        end
        RSP_READY = 1'b1;
        #1;
        check("b2b_req_ready", REQ_READY, 32'h1);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0; RSP_READY = 1'b0;
        @(negedge CLK);
        check("b2b_valid", RSP_VALID, 32'h1);
        check("b2b_out",   OUT,       32'h00000007);
        RSP_READY = 1'b1;
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;

        // Reset in the middle of an SLL by 20.
        @(negedge CLK);
        REQ_VALID = 1'b1; A = 32'h00000001; B = 32'h00000014; CTRL = 4'b0100;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("mid_rst_out",       OUT,         32'h0);
        check("mid_rst_rsp_valid", RSP_VALID,   32'h0);
        check("mid_rst_zero",      ZERO_SIGNAL, 32'h0);
        check("mid_rst_bad",       BAD_OP,      32'h0);
        check("mid_rst_req_ready", REQ_READY,   32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_req_ready", REQ_READY, 32'h1);
        stale = 0;
        RSP_READY = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (RSP_VALID) stale++;
        end
        RSP_READY = 1'b0;
        check("no_stale_rsp", 32'(stale), 32'h0);

        run_op(32'h00000010, 32'h00000020, 4'b0000, got_out, got_zero, got_bad, got_lat);
        check("recover_out", got_out,      32'h00000030);
        check("recover_lat", 32'(got_lat), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
